// File: rtl/decode_pkg.sv
// Shared opcode/ALU constants, decoded-control struct and instruction decoder
// for the decode_pipe stage.
package decode_pkg;

  localparam int REG_AW    = 3;
  localparam int NREGS_ISA = 8;

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_BR    = 4'b0010;
  localparam logic [3:0] OP_JMP   = 4'b0100;
  localparam logic [3:0] OP_ST    = 4'b0111;
  localparam logic [3:0] OP_LD    = 4'b1000;
  localparam logic [3:0] OP_ALUR0 = 4'b1010;
  localparam logic [3:0] OP_ALUR1 = 4'b1011;
  localparam logic [3:0] OP_ALUI0 = 4'b1100;
  localparam logic [3:0] OP_ALUI1 = 4'b1101;
  localparam logic [3:0] OP_ALUI2 = 4'b1110;
  localparam logic [3:0] OP_ALUI3 = 4'b1111;

  localparam logic [3:0] ALU_I0      = 4'b0000;
  localparam logic [3:0] ALU_I1      = 4'b0001;
  localparam logic [3:0] ALU_I2      = 4'b0010;
  localparam logic [3:0] ALU_I3      = 4'b0011;
  localparam logic [3:0] ALU_R1_ZERO = 4'b1000;
  localparam logic [3:0] ALU_NOP     = 4'b1111;

  typedef enum logic {ST_RUN, ST_HALTED} pipe_state_t;

  typedef struct packed {
    logic              branch;
    logic              jump;
    logic              rq_imm;
    logic              rs_imm;
    logic              mem_write;
    logic              mem_read;
    logic              halt;
    logic              wen;
    logic [3:0]        alu_ctrl;
    logic [REG_AW-1:0] wreg;
    logic [REG_AW-1:0] rq;
    logic [REG_AW-1:0] rs;
  } decode_ctrl_t;

  localparam decode_ctrl_t CTRL_RESET = '{alu_ctrl: ALU_NOP, default: '0};

  function automatic decode_ctrl_t decode_inst(input logic [15:0] inst);
    decode_ctrl_t c;
    logic [3:0]   op;
    op          = inst[15:12];
    c           = '0;
    c.halt      = (op == OP_HALT);
    c.branch    = (op == OP_BR);
    c.jump      = (op == OP_JMP);
    c.mem_write = (op == OP_ST);
    c.mem_read  = (op == OP_LD);
    c.rq_imm    = c.mem_write | c.mem_read;
    c.rs_imm    = inst[15] & inst[14] & ~c.halt;
    c.wen       = inst[15];
    c.wreg      = inst[11:9];
    c.rq        = inst[14] ? inst[11:9] : inst[5:3];
    c.rs        = inst[8:6];
    case (op)
      OP_ALUI0: c.alu_ctrl = ALU_I0;
      OP_ALUI1: c.alu_ctrl = ALU_I1;
      OP_ALUI2: c.alu_ctrl = ALU_I2;
      OP_ALUI3: c.alu_ctrl = ALU_I3;
      OP_ALUR1: c.alu_ctrl = (inst[2:0] != 3'b000) ? {1'b0, inst[2:0]} : ALU_R1_ZERO;
      OP_ALUR0: c.alu_ctrl = {1'b1, inst[2:0]};
      default:  c.alu_ctrl = ALU_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_rf.sv
// 8-entry register file: two combinational reads, one synchronous write.
// With DECODE_BYPASS_EN defined, a same-cycle write is forwarded to the reads.
module decode_rf
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_reg,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [REG_AW-1:0] i_rd_a_addr,
  input  logic [REG_AW-1:0] i_rd_b_addr,
  output logic [DATA_W-1:0] o_rd_a_data,
  output logic [DATA_W-1:0] o_rd_b_data
);

  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_wb_en) begin
      r_regs[i_wb_reg] <= i_wb_data;
    end
  end

`ifdef DECODE_BYPASS_EN
  assign o_rd_a_data = (i_wb_en && i_wb_reg == i_rd_a_addr) ? i_wb_data : r_regs[i_rd_a_addr];
  assign o_rd_b_data = (i_wb_en && i_wb_reg == i_rd_b_addr) ? i_wb_data : r_regs[i_rd_b_addr];
`else
  assign o_rd_a_data = r_regs[i_rd_a_addr];
  assign o_rd_b_data = r_regs[i_rd_b_addr];
`endif

endmodule

// File: rtl/decode_pipe.sv
// Registered decode stage: register file, field decode, load-use interlock,
// flush, sticky halt and ID/EX register. Optional macro: DECODE_BYPASS_EN.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_pc_plus1,
  input  logic [15:0]       in_inst,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [15:0]       out_inst,
  output logic              out_branch,
  output logic              out_jump,
  output logic              out_rq_imm,
  output logic              out_rs_imm,
  output logic              out_mem_write,
  output logic              out_mem_read,
  output logic              out_halt,
  output logic              out_wen,
  output logic [3:0]        out_alu_ctrl,
  output logic [DATA_W-1:0] out_reg1,
  output logic [DATA_W-1:0] out_reg2,
  output logic [2:0]        out_wreg,
  output logic [2:0]        out_rq,
  output logic [2:0]        out_rs,
  output logic              halted
);

  if (NREGS != NREGS_ISA) begin : g_bad_nregs
    $error("decode_pipe: NREGS must be 8 (3-bit register fields)");
  end

  decode_ctrl_t      w_dec;
  logic [DATA_W-1:0] w_rq_data;
  logic [DATA_W-1:0] w_rs_data;
  logic              w_hazard;
  logic              w_accept;

  pipe_state_t       r_state;
  logic              r_halted;
  logic              r_vld_p1;
  decode_ctrl_t      r_ctrl_p1;
  logic [PC_W-1:0]   r_pc_p1;
  logic [15:0]       r_inst_p1;
  logic [DATA_W-1:0] r_reg1_p1;
  logic [DATA_W-1:0] r_reg2_p1;

  assign w_dec = decode_inst(in_inst);

  decode_rf #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk         (clk),
    .rst         (rst),
    .i_wb_en     (wb_en),
    .i_wb_reg    (wb_reg),
    .i_wb_data   (wb_data),
    .i_rd_a_addr (w_dec.rq),
    .i_rd_b_addr (w_dec.rs),
    .o_rd_a_data (w_rq_data),
    .o_rd_b_data (w_rs_data)
  );

  // Both source fields are compared even when one is an immediate slot.
  assign w_hazard = r_vld_p1 & r_ctrl_p1.mem_read
                  & (in_inst[15:12] != OP_HALT) & (in_inst[15:12] != OP_JMP)
                  & ((r_ctrl_p1.wreg == w_dec.rq) | (r_ctrl_p1.wreg == w_dec.rs));

  assign in_ready = rst & ~r_halted & ~w_hazard & (~r_vld_p1 | out_ready);
  assign w_accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept && w_dec.halt) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end
        end
        ST_HALTED: begin
          r_state  <= ST_HALTED;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= ST_RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // ID/EX boundary (p1)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1  <= 1'b0;
      r_ctrl_p1 <= CTRL_RESET;
      r_pc_p1   <= '0;
      r_inst_p1 <= '0;
      r_reg1_p1 <= '0;
      r_reg2_p1 <= '0;
    end else begin
      if (flush)         r_vld_p1 <= 1'b0;
      else if (w_accept) r_vld_p1 <= 1'b1;
      else if (out_ready) r_vld_p1 <= 1'b0;

      if (w_accept) begin
        r_ctrl_p1 <= w_dec;
        r_pc_p1   <= w_dec.halt ? in_pc : in_pc_plus1;
        r_inst_p1 <= in_inst;
        r_reg1_p1 <= w_rq_data;
        r_reg2_p1 <= w_rs_data;
      end
    end
  end

  assign out_valid     = r_vld_p1;
  assign out_pc        = r_pc_p1;
  assign out_inst      = r_inst_p1;
  assign out_branch    = r_ctrl_p1.branch;
  assign out_jump      = r_ctrl_p1.jump;
  assign out_rq_imm    = r_ctrl_p1.rq_imm;
  assign out_rs_imm    = r_ctrl_p1.rs_imm;
  assign out_mem_write = r_ctrl_p1.mem_write;
  assign out_mem_read  = r_ctrl_p1.mem_read;
  assign out_halt      = r_ctrl_p1.halt;
  assign out_wen       = r_ctrl_p1.wen;
  assign out_alu_ctrl  = r_ctrl_p1.alu_ctrl;
  assign out_wreg      = r_ctrl_p1.wreg;
  assign out_rq        = r_ctrl_p1.rq;
  assign out_rs        = r_ctrl_p1.rs;
  assign out_reg1      = r_reg1_p1;
  assign out_reg2      = r_reg2_p1;
  assign halted        = r_halted;

endmodule
